// File: rtl/boot_rom_arbiter.sv
// -----------------------------------------------------------------------------
// boot_rom_arbiter
//
// Shares the single-port boot ROM between the instruction-fetch port and the
// data/debug read port. Both ports use a req/gnt/rvalid handshake: gnt is
// combinational in the request cycle, and the response (rvalid/rdata/err)
// appears exactly one cycle later. Conflicts are settled round-robin.
// Misaligned, out-of-range and write accesses are granted but answered with an
// error response, and they never select the ROM.
//
// Ports:
//   CLK, RSTN                      clock, asynchronous active-low reset
//   instr_req_i / instr_addr_i     instruction-fetch request and byte address
//   instr_gnt_o                    instruction request accepted this cycle
//   instr_rvalid_o/_rdata_o/_err_o instruction response (one cycle after gnt)
//   data_req_i / data_addr_i       data/debug request and byte address
//   data_we_i                      data write enable (always answered with err)
//   data_gnt_o                     data request accepted this cycle
//   data_rvalid_o/_rdata_o/_err_o  data response (one cycle after gnt)
//   rom_csn_o / rom_a_o            ROM chip select (active low) and word address
//   rom_q_i                        ROM data, valid the cycle after capture
// -----------------------------------------------------------------------------
module boot_rom_arbiter #(
    parameter int ROM_WORDS  = 548,
    parameter int ROM_AW     = 10,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RSTN,

    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [31:0]           instr_rdata_o,
    output logic                  instr_err_o,

    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [31:0]           data_rdata_o,
    output logic                  data_err_o,

    output logic                  rom_csn_o,
    output logic [ROM_AW-1:0]     rom_a_o,
    input  logic [31:0]           rom_q_i
);

    // Which port was granted most recently; the other port wins a conflict.
    typedef enum logic {
        GRANT_INSTR = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_e;

    // One extra bit so the limit 548 compares cleanly against a 10-bit word.
    localparam logic [ROM_AW:0] ROM_LIMIT = (ROM_AW + 1)'(ROM_WORDS);

    grant_e            last_grant;
    logic              instr_pend_valid;
    logic              instr_pend_err;
    logic              data_pend_valid;
    logic              data_pend_err;

    logic [ROM_AW-1:0] instr_word;
    logic [ROM_AW-1:0] data_word;
    logic              instr_bad;
    logic              data_bad;

    // Address bits above the ROM window are decoded upstream and ignored here.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{instr_addr_i[ADDR_WIDTH-1:ROM_AW+2],
                                data_addr_i[ADDR_WIDTH-1:ROM_AW+2]};

    // -------------------------------------------------------------------------
    // Address decode and error classification
    // -------------------------------------------------------------------------
    assign instr_word = instr_addr_i[ROM_AW+1:2];
    assign data_word  = data_addr_i[ROM_AW+1:2];

    assign instr_bad = (instr_addr_i[1:0] != 2'b00) ||
                       ({1'b0, instr_word} >= ROM_LIMIT);
    assign data_bad  = (data_addr_i[1:0] != 2'b00) ||
                       ({1'b0, data_word} >= ROM_LIMIT) ||
                       data_we_i;

    // -------------------------------------------------------------------------
    // Round-robin grant: a lone requester always wins; on a conflict the port
    // that was not granted last goes first. At most one gnt per cycle.
    // -------------------------------------------------------------------------
    assign instr_gnt_o = instr_req_i && (!data_req_i || last_grant == GRANT_DATA);
    assign data_gnt_o  = data_req_i  && (!instr_req_i || last_grant == GRANT_INSTR);

    // -------------------------------------------------------------------------
    // ROM drive: only a granted, error-free access selects the ROM. An error
    // access leaves csn high so the ROM keeps its previously captured word.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latches.
        rom_csn_o = 1'b1;
        rom_a_o   = '0;
        if (instr_gnt_o && !instr_bad) begin
            rom_csn_o = 1'b0;
            rom_a_o   = instr_word;
        end else if (data_gnt_o && !data_bad) begin
            rom_csn_o = 1'b0;
            rom_a_o   = data_word;
        end
    end

    // -------------------------------------------------------------------------
    // Arbiter state and per-port pending-response registers. Reset discards
    // anything in flight, so no response escapes for pre-reset grants.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            last_grant       <= GRANT_DATA;
            instr_pend_valid <= 1'b0;
            instr_pend_err   <= 1'b0;
            data_pend_valid  <= 1'b0;
            data_pend_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            if (instr_gnt_o) begin
                last_grant <= GRANT_INSTR;
            end else if (data_gnt_o) begin
                last_grant <= GRANT_DATA;
            end
            instr_pend_valid <= instr_gnt_o;
            instr_pend_err   <= instr_gnt_o && instr_bad;
            data_pend_valid  <= data_gnt_o;
            data_pend_err    <= data_gnt_o && data_bad;
        end
    end

    // -------------------------------------------------------------------------
    // Responses: the ROM word captured at the end of the grant cycle is on
    // rom_q_i now. Error responses and idle cycles return zero data.
    // -------------------------------------------------------------------------
    assign instr_rvalid_o = instr_pend_valid;
    assign instr_err_o    = instr_pend_valid && instr_pend_err;
    assign instr_rdata_o  = (instr_pend_valid && !instr_pend_err) ? rom_q_i : 32'h0;

    assign data_rvalid_o  = data_pend_valid;
    assign data_err_o     = data_pend_valid && data_pend_err;
    assign data_rdata_o   = (data_pend_valid && !data_pend_err) ? rom_q_i : 32'h0;

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_boot_rom_arbiter
//
// Directed bench for boot_rom_arbiter. A small synchronous ROM model supplies
// rom_q_i one cycle after the address is captured. Inputs are driven 1 time
// unit after the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_boot_rom_arbiter;

    localparam int ROM_WORDS  = 548;
    localparam int ROM_AW     = 10;
    localparam int ADDR_WIDTH = 32;

    logic                  CLK;
    logic                  RSTN;
    logic                  instr_req_i;
    logic [ADDR_WIDTH-1:0] instr_addr_i;
    logic                  instr_gnt_o;
    logic                  instr_rvalid_o;
    logic [31:0]           instr_rdata_o;
    logic                  instr_err_o;
    logic                  data_req_i;
    logic [ADDR_WIDTH-1:0] data_addr_i;
    logic                  data_we_i;
    logic                  data_gnt_o;
    logic                  data_rvalid_o;
    logic [31:0]           data_rdata_o;
    logic                  data_err_o;
    logic                  rom_csn_o;
    logic [ROM_AW-1:0]     rom_a_o;
    logic [31:0]           rom_q_i;

    int checks = 0;
    int errors = 0;

    boot_rom_arbiter #(
        .ROM_WORDS  (ROM_WORDS),
        .ROM_AW     (ROM_AW),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .CLK            (CLK),
        .RSTN           (RSTN),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req_i),
        .data_addr_i    (data_addr_i),
        .data_we_i      (data_we_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .rom_csn_o      (rom_csn_o),
        .rom_a_o        (rom_a_o),
        .rom_q_i        (rom_q_i)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ROM contents: a few named words, everything else 0xDEAD0000 | index.
    function automatic logic [31:0] rom_word(input logic [ROM_AW-1:0] idx);
        case (idx)
            10'd0, 10'd1: rom_word = 32'h0000_0013;
            10'd31:       rom_word = 32'h0100_006F;
            10'd36:       rom_word = 32'h0000_0093;
            10'd37:       rom_word = 32'h8186_8106;
            10'd38:       rom_word = 32'h8286_8206;
            10'd39:       rom_word = 32'h8386_8306;
            10'd40:       rom_word = 32'h8486_8406;
            10'd136:      rom_word = 32'h0000_8067;
            default:      rom_word = {16'hDEAD, 6'b0, idx};
        endcase
    endfunction

    // Synchronous single-port ROM: captures the address when selected.
    logic [ROM_AW-1:0] rom_cap = '0;
    always @(posedge CLK) begin
        if (!rom_csn_o) rom_cap <= rom_a_o;
    end
    assign rom_q_i = rom_word(rom_cap);

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive after the rising edge, settle to the falling edge.
    task automatic apply(input logic ireq, input logic [31:0] iaddr,
                         input logic dreq, input logic [31:0] daddr,
                         input logic dwe);
        @(posedge CLK);
        #1;
        instr_req_i  = ireq;
        instr_addr_i = iaddr;
        data_req_i   = dreq;
        data_addr_i  = daddr;
        data_we_i    = dwe;
        @(negedge CLK);
    endtask

    typedef struct {
        logic              ireq;
        logic [31:0]       iaddr;
        logic              dreq;
        logic [31:0]       daddr;
        logic              dwe;
        logic              igt;
        logic              dgt;
        logic              csn;
        logic [ROM_AW-1:0] a;
        logic              iv;
        logic              ie;
        logic [31:0]       ird;
        logic              dv;
        logic              de;
        logic [31:0]       drd;
    } vec_t;

    function automatic vec_t mk(
        input logic ireq, input logic [31:0] iaddr,
        input logic dreq, input logic [31:0] daddr, input logic dwe,
        input logic igt, input logic dgt, input logic csn,
        input logic [ROM_AW-1:0] a,
        input logic iv, input logic ie, input logic [31:0] ird,
        input logic dv, input logic de, input logic [31:0] drd);
        vec_t v;
        v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.daddr = daddr;
        v.dwe = dwe; v.igt = igt; v.dgt = dgt; v.csn = csn; v.a = a;
        v.iv = iv; v.ie = ie; v.ird = ird; v.dv = dv; v.de = de; v.drd = drd;
        return v;
    endfunction

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    initial begin
        logic [31:0] burst_exp [5];

        RSTN         = 1'b0;
        instr_req_i  = 1'b0;
        instr_addr_i = '0;
        data_req_i   = 1'b0;
        data_addr_i  = '0;
        data_we_i    = 1'b0;

        //             ireq iaddr        dreq daddr      we  igt dgt csn a     iv ie ird           dv de drd
        // Conflict from reset: instr first, then data.
        vecs[0]  = mk(1, 32'h0,       1, 32'h4,   0,  1, 0, 0, 10'd0,  0, 0, 32'h0,         0, 0, 32'h0);
        vecs[1]  = mk(0, 32'h0,       1, 32'h4,   0,  0, 1, 0, 10'd1,  1, 0, 32'h13,        0, 0, 32'h0);
        vecs[2]  = mk(0, 32'h0,       0, 32'h0,   0,  0, 0, 1, 10'd0,  0, 0, 32'h0,         1, 0, 32'h13);
        // Single instruction fetch of word 31.
        vecs[3]  = mk(1, 32'h7C,      0, 32'h0,   0,  1, 0, 0, 10'd31, 0, 0, 32'h0,         0, 0, 32'h0);
        vecs[4]  = mk(0, 32'h0,       0, 32'h0,   0,  0, 0, 1, 10'd0,  1, 0, 32'h0100006F,  0, 0, 32'h0);
        // Data alone leaves last_grant=DATA, then six alternating grants I,D,I,D,I,D.
        vecs[5]  = mk(0, 32'h0,       1, 32'h8,   0,  0, 1, 0, 10'd2,  0, 0, 32'h0,         0, 0, 32'h0);
        vecs[6]  = mk(1, 32'h10,      1, 32'h20,  0,  1, 0, 0, 10'd4,  0, 0, 32'h0,         1, 0, 32'hDEAD0002);
        vecs[7]  = mk(1, 32'h14,      1, 32'h20,  0,  0, 1, 0, 10'd8,  1, 0, 32'hDEAD0004,  0, 0, 32'h0);
        vecs[8]  = mk(1, 32'h14,      1, 32'h24,  0,  1, 0, 0, 10'd5,  0, 0, 32'h0,         1, 0, 32'hDEAD0008);
        vecs[9]  = mk(1, 32'h18,      1, 32'h24,  0,  0, 1, 0, 10'd9,  1, 0, 32'hDEAD0005,  0, 0, 32'h0);
        vecs[10] = mk(1, 32'h18,      1, 32'h28,  0,  1, 0, 0, 10'd6,  0, 0, 32'h0,         1, 0, 32'hDEAD0009);
        vecs[11] = mk(0, 32'h0,       1, 32'h28,  0,  0, 1, 0, 10'd10, 1, 0, 32'hDEAD0006,  0, 0, 32'h0);
        vecs[12] = mk(0, 32'h0,       0, 32'h0,   0,  0, 0, 1, 10'd0,  0, 0, 32'h0,         1, 0, 32'hDEAD000A);
        // Data errors: word 548, misaligned, write.
        vecs[13] = mk(0, 32'h0,       1, 32'h890, 0,  0, 1, 1, 10'd0,  0, 0, 32'h0,         0, 0, 32'h0);
        vecs[14] = mk(0, 32'h0,       1, 32'h2,   0,  0, 1, 1, 10'd0,  0, 0, 32'h0,         1, 1, 32'h0);
        vecs[15] = mk(0, 32'h0,       1, 32'h0,   1,  0, 1, 1, 10'd0,  0, 0, 32'h0,         1, 1, 32'h0);
        vecs[16] = mk(0, 32'h0,       0, 32'h0,   0,  0, 0, 1, 10'd0,  0, 0, 32'h0,         1, 1, 32'h0);
        // Instr misaligned error, then last valid word 547, then high bits ignored.
        vecs[17] = mk(1, 32'h7E,      0, 32'h0,   0,  1, 0, 1, 10'd0,  0, 0, 32'h0,         0, 0, 32'h0);
        vecs[18] = mk(1, 32'h88C,     0, 32'h0,   0,  1, 0, 0, 10'd547,1, 1, 32'h0,         0, 0, 32'h0);
        vecs[19] = mk(0, 32'h0,       0, 32'h0,   0,  0, 0, 1, 10'd0,  1, 0, 32'hDEAD0223,  0, 0, 32'h0);
        vecs[20] = mk(1, 32'h80000004,0, 32'h0,   0,  1, 0, 0, 10'd1,  0, 0, 32'h0,         0, 0, 32'h0);
        vecs[21] = mk(0, 32'h0,       0, 32'h0,   0,  0, 0, 1, 10'd0,  1, 0, 32'h13,        0, 0, 32'h0);

        burst_exp[0] = 32'h0000_0093;
        burst_exp[1] = 32'h8186_8106;
        burst_exp[2] = 32'h8286_8206;
        burst_exp[3] = 32'h8386_8306;
        burst_exp[4] = 32'h8486_8406;

        // ---------------- Reset state ----------------
        @(negedge CLK);
        @(negedge CLK);
        check("rst instr_rvalid", 32'(instr_rvalid_o), 32'h0);
        check("rst instr_err",    32'(instr_err_o),    32'h0);
        check("rst instr_rdata",  instr_rdata_o,       32'h0);
        check("rst data_rvalid",  32'(data_rvalid_o),  32'h0);
        check("rst data_err",     32'(data_err_o),     32'h0);
        check("rst data_rdata",   data_rdata_o,        32'h0);
        check("rst rom_csn",      32'(rom_csn_o),      32'h1);
        check("rst rom_a",        32'(rom_a_o),        32'h0);
        RSTN = 1'b1;

        // ---------------- Table-driven vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].daddr, vecs[i].dwe);
            check($sformatf("v%0d instr_gnt", i),    32'(instr_gnt_o),    32'(vecs[i].igt));
            check($sformatf("v%0d data_gnt", i),     32'(data_gnt_o),     32'(vecs[i].dgt));
            check($sformatf("v%0d rom_csn", i),      32'(rom_csn_o),      32'(vecs[i].csn));
            check($sformatf("v%0d rom_a", i),        32'(rom_a_o),        32'(vecs[i].a));
            check($sformatf("v%0d instr_rvalid", i), 32'(instr_rvalid_o), 32'(vecs[i].iv));
            check($sformatf("v%0d instr_err", i),    32'(instr_err_o),    32'(vecs[i].ie));
            check($sformatf("v%0d instr_rdata", i),  instr_rdata_o,       vecs[i].ird);
            check($sformatf("v%0d data_rvalid", i),  32'(data_rvalid_o),  32'(vecs[i].dv));
            check($sformatf("v%0d data_err", i),     32'(data_err_o),     32'(vecs[i].de));
            check($sformatf("v%0d data_rdata", i),   data_rdata_o,        vecs[i].drd);
        end

        // ---------------- Five back-to-back instruction fetches ----------------
        for (int k = 0; k < 5; k++) begin
            apply(1'b1, 32'h90 + 32'(4 * k), 1'b0, 32'h0, 1'b0);
            check($sformatf("burst%0d instr_gnt", k), 32'(instr_gnt_o), 32'h1);
            check($sformatf("burst%0d rom_a", k),     32'(rom_a_o),     32'(36 + k));
            if (k > 0) begin
                check($sformatf("burst%0d instr_rvalid", k), 32'(instr_rvalid_o), 32'h1);
                check($sformatf("burst%0d instr_rdata", k),  instr_rdata_o,       burst_exp[k-1]);
            end
        end
        apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("burst4 instr_rvalid", 32'(instr_rvalid_o), 32'h1);
        check("burst4 instr_rdata",  instr_rdata_o,       burst_exp[4]);
        apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("burst end instr_rvalid", 32'(instr_rvalid_o), 32'h0);

        // ---------------- Reset mid-operation ----------------
        // last_grant is INSTR here; after reset it must be DATA again.
        apply(1'b1, 32'h220, 1'b0, 32'h0, 1'b0);
        check("mid instr_gnt", 32'(instr_gnt_o), 32'h1);
        check("mid rom_a",     32'(rom_a_o),     32'd136);
        @(posedge CLK);
        #1;
        instr_req_i = 1'b0;
        instr_addr_i = '0;
        RSTN = 1'b0;
        @(negedge CLK);
        check("in-reset instr_rvalid", 32'(instr_rvalid_o), 32'h0);
        check("in-reset instr_rdata",  instr_rdata_o,       32'h0);
        RSTN = 1'b1;
        apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("post-reset instr_rvalid", 32'(instr_rvalid_o), 32'h0);
        check("post-reset data_rvalid",  32'(data_rvalid_o),  32'h0);
        apply(1'b1, 32'h0, 1'b1, 32'h4, 1'b0);
        check("post-reset conflict instr_gnt", 32'(instr_gnt_o), 32'h1);
        check("post-reset conflict data_gnt",  32'(data_gnt_o),  32'h0);
        check("post-reset instr_rvalid2",      32'(instr_rvalid_o), 32'h0);
        apply(1'b0, 32'h0, 1'b1, 32'h4, 1'b0);
        check("post-reset data_gnt",     32'(data_gnt_o),     32'h1);
        check("post-reset instr_rvalid3", 32'(instr_rvalid_o), 32'h1);
        check("post-reset instr_rdata",  instr_rdata_o,       32'h13);
        apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("post-reset data_rvalid2", 32'(data_rvalid_o), 32'h1);
        check("post-reset data_rdata",   data_rdata_o,       32'h13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
